// File: rtl/monopix_core_if.sv
// monopix_core_if: token/freeze/read readout handshake between the pixel core and the readout controller
interface monopix_core_if;
    logic freeze;
    logic read;
    logic token;
    logic data_out;
    logic hit_or;
    modport master (output freeze, read, input token, data_out, hit_or);
    modport slave (input freeze, read, output token, data_out, hit_or);
endinterface

// File: rtl/monopix_core.sv
// monopix_core: pixel hit time-stamping, priority arbitration and 27-bit serial readout (optional MONOPIX_TEST_PATTERN_EN adds en_test_pattern)
module monopix_core #(
    parameter int NCOL = 4,
    parameter int NROW = 8
) (
    input  logic                 clk_bx,
    input  logic                 reset,
    input  logic                 reset_bcid,
    input  logic [NROW*NCOL-1:0] ana_hit,
    input  logic [NCOL-1:0]      en_col,
    input  logic                 inj_pulse,
    input  logic [NCOL-1:0]      inj_col,
    input  logic [NROW-1:0]      inj_row,
    input  logic [NCOL-1:0]      dig_mon_sel,
`ifdef MONOPIX_TEST_PATTERN_EN
    input  logic                 en_test_pattern,
`endif
    monopix_core_if.slave        ro
);
    localparam int NPIX = NROW * NCOL;
    typedef enum logic [1:0] {IDLE, HIGH, DONE} pix_state_t;
    pix_state_t      state [NPIX];
    pix_state_t      state_nx [NPIX];
    logic [5:0]      le [NPIX];
    logic [5:0]      le_nx [NPIX];
    logic [5:0]      te [NPIX];
    logic [5:0]      te_nx [NPIX];
    logic [NPIX-1:0] eff, prev, ready, ready_q, win_1h, clr;
    logic [5:0]      bcid, gray, win_col, win_le, win_te;
    logic [8:0]      win_row;
    logic [26:0]     sr, word;
    logic            read_q, rd_edge, any_ready, tp, token_q, data_q, hit_or_q;

`ifdef MONOPIX_TEST_PATTERN_EN
    assign tp = en_test_pattern;
`else
    assign tp = 1'b0;
`endif

    assign gray        = bcid ^ (bcid >> 1);
    assign rd_edge     = ro.read & ~read_q;
    assign clr         = (rd_edge & ~tp) ? win_1h : '0;
    assign word        = tp ? {6'h3F, 6'h15, 6'h2A, 9'h155}
                            : any_ready ? {win_col, win_te, win_le, win_row} : '0;
    assign ro.token    = token_q;
    assign ro.data_out = data_q;
    assign ro.hit_or   = hit_or_q;

    // effective hits and ready set; during freeze only pixels already ready stay ready
    always_comb begin
        eff   = '0;
        ready = '0;
        for (int c = 0; c < NCOL; c++)
            for (int r = 0; r < NROW; r++) begin
                eff[r*NCOL+c]   = en_col[c] & (ana_hit[r*NCOL+c] | (inj_pulse & inj_col[c] & inj_row[r]));
                ready[r*NCOL+c] = (state[r*NCOL+c] == DONE) & (~ro.freeze | ready_q[r*NCOL+c]);
            end
    end

    // priority pick: scanning from the far corner lets the lowest column, then lowest row, win
    always_comb begin
        any_ready = 1'b0;
        win_1h    = '0;
        win_col   = '0;
        win_row   = '0;
        win_le    = '0;
        win_te    = '0;
        for (int c = NCOL - 1; c >= 0; c--)
            for (int r = NROW - 1; r >= 0; r--)
                if (ready[r*NCOL+c]) begin
                    any_ready = 1'b1;
                    win_1h    = '0;
                    win_1h[r*NCOL+c] = 1'b1;
                    win_col   = 6'(c);
                    win_row   = 9'(r);
                    win_le    = le[r*NCOL+c];
                    win_te    = te[r*NCOL+c];
                end
    end

    // per-pixel next state: a clear overrides any edge seen in the same cycle
    always_comb begin
        for (int p = 0; p < NPIX; p++) begin
            state_nx[p] = state[p];
            le_nx[p]    = le[p];
            te_nx[p]    = te[p];
            if (clr[p])
                state_nx[p] = IDLE;
            else if (state[p] == IDLE && eff[p] && !prev[p]) begin
                state_nx[p] = HIGH;
                le_nx[p]    = gray;
            end else if (state[p] == HIGH && !eff[p] && prev[p]) begin
                state_nx[p] = DONE;
                te_nx[p]    = gray;
            end
        end
    end

    // pixel state, time stamps and edge-detect history
    always_ff @(posedge clk_bx or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < NPIX; p++) begin
                state[p] <= IDLE;
                le[p]    <= '0;
                te[p]    <= '0;
            end
            prev    <= '0;
            ready_q <= '0;
        end else begin
            for (int p = 0; p < NPIX; p++) begin
                state[p] <= state_nx[p];
                le[p]    <= le_nx[p];
                te[p]    <= te_nx[p];
            end
            prev    <= eff;
            ready_q <= ready;
        end
    end

    // BCID counter, read edge history, serialiser and registered status outputs
    always_ff @(posedge clk_bx or posedge reset) begin
        if (reset) begin
            bcid     <= '0;
            read_q   <= 1'b0;
            sr       <= '0;
            data_q   <= 1'b0;
            token_q  <= 1'b0;
            hit_or_q <= 1'b0;
        end else begin
            bcid     <= reset_bcid ? 6'd0 : bcid + 6'd1;
            read_q   <= ro.read;
            sr       <= rd_edge ? word : {sr[25:0], 1'b0};
            data_q   <= sr[26];
            token_q  <= tp | (|ready);
            hit_or_q <= |(eff & {NROW{dig_mon_sel}});
        end
    end
endmodule

// File: tb/tb_monopix_core.sv
// tb_monopix_core: directed and randomized checks of monopix_core against a behavioural model
module tb_monopix_core;
    localparam int NCOL = 4;
    localparam int NROW = 8;
    localparam int NPIX = NCOL * NROW;

    logic            clk_bx, reset, reset_bcid, inj_pulse;
    logic [NPIX-1:0] ana_hit;
    logic [NCOL-1:0] en_col, inj_col, dig_mon_sel;
    logic [NROW-1:0] inj_row;
`ifdef MONOPIX_TEST_PATTERN_EN
    logic            en_test_pattern = 1'b0;
`endif
    monopix_core_if ro();

    monopix_core #(.NCOL(NCOL), .NROW(NROW)) dut (
        .clk_bx(clk_bx), .reset(reset), .reset_bcid(reset_bcid), .ana_hit(ana_hit),
        .en_col(en_col), .inj_pulse(inj_pulse), .inj_col(inj_col), .inj_row(inj_row),
        .dig_mon_sel(dig_mon_sel),
`ifdef MONOPIX_TEST_PATTERN_EN
        .en_test_pattern(en_test_pattern),
`endif
        .ro(ro)
    );

    initial begin
        clk_bx = 1'b0;
        forever #5 clk_bx = ~clk_bx;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int         checks = 0;
    int         errors = 0;
    int         m_st [NPIX];
    logic [5:0] m_le [NPIX];
    logic [5:0] m_te [NPIX];
    bit         m_prev [NPIX];
    bit         m_rdyq [NPIX];
    int         m_bx;
    bit         m_read;
    bit         bits [$];
    bit         e_token, e_do, e_hor;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] g2b(logic [5:0] g);
        logic [5:0] b;
        b[5] = g[5];
        for (int i = 4; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    // advance the model by one clock edge using the inputs currently driven
    task automatic step();
        bit         e [NPIX];
        bit         rdy [NPIX];
        int         win;
        bit         rd_edge;
        logic [5:0] g;
        logic [26:0] w;
        win = -1;
        g = 6'(m_bx ^ (m_bx >> 1));
        e_token = 0;
        e_hor = 0;
        for (int c = 0; c < NCOL; c++)
            for (int r = 0; r < NROW; r++) begin
                int p;
                p = r * NCOL + c;
                e[p] = en_col[c] && (ana_hit[p] || (inj_pulse && inj_col[c] && inj_row[r]));
                rdy[p] = (m_st[p] == 2) && (!ro.freeze || m_rdyq[p]);
                if (rdy[p]) e_token = 1;
                if (rdy[p] && win < 0) win = p;
                if (e[p] && dig_mon_sel[c]) e_hor = 1;
            end
        e_do = bits.size() > 0 ? bits.pop_front() : 1'b0;
        rd_edge = ro.read && !m_read;
        if (rd_edge) begin
            w = '0;
            if (win >= 0) w = {6'(win % NCOL), m_te[win], m_le[win], 9'(win / NCOL)};
            bits.delete();
            for (int i = 26; i >= 0; i--) bits.push_back(w[i]);
        end
        for (int p = 0; p < NPIX; p++) begin
            if (rd_edge && p == win) m_st[p] = 0;
            else if (m_st[p] == 0 && e[p] && !m_prev[p]) begin m_st[p] = 1; m_le[p] = g; end
            else if (m_st[p] == 1 && !e[p] && m_prev[p]) begin m_st[p] = 2; m_te[p] = g; end
            m_prev[p] = e[p];
            m_rdyq[p] = rdy[p];
        end
        m_read = ro.read;
        m_bx = reset_bcid ? 0 : (m_bx + 1) % 64;
    endtask

    task automatic cyc();
        step();
        @(posedge clk_bx);
        #1;
        chk("token", 32'(ro.token), 32'(e_token));
        chk("data_out", 32'(ro.data_out), 32'(e_do));
        chk("hit_or", 32'(ro.hit_or), 32'(e_hor));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #3;
        for (int p = 0; p < NPIX; p++) begin
            m_st[p] = 0; m_le[p] = '0; m_te[p] = '0; m_prev[p] = 0; m_rdyq[p] = 0;
        end
        m_bx = 0;
        m_read = 0;
        bits.delete();
        chk("rst_token", 32'(ro.token), 32'd0);
        chk("rst_data_out", 32'(ro.data_out), 32'd0);
        chk("rst_hit_or", 32'(ro.hit_or), 32'd0);
        @(posedge clk_bx);
        #1;
        reset = 1'b0;
    endtask

    task automatic read_word(output logic [26:0] w);
        w = '0;
        ro.read = 1'b1;
        cyc();
        ro.read = 1'b0;
        for (int i = 0; i < 27; i++) begin
            cyc();
            w = {w[25:0], ro.data_out};
        end
    endtask

    initial begin
        logic [26:0] w;
        int cnt;
        reset = 1'b0; reset_bcid = 1'b0; ana_hit = '0; en_col = '1; inj_pulse = 1'b0;
        inj_col = '0; inj_row = '0; dig_mon_sel = '0; ro.freeze = 1'b0; ro.read = 1'b0;
        #2;
        do_reset();

        // 1: single 8-cycle hit at (r0,c0)
        ana_hit[0] = 1'b1;
        repeat (8) cyc();
        ana_hit[0] = 1'b0;
        cyc();
        chk("t1_token_before", 32'(ro.token), 32'd0);
        cyc();
        chk("t1_token_rise", 32'(ro.token), 32'd1);
        read_word(w);
        chk("t1_col", 32'(w[26:21]), 32'd0);
        chk("t1_row", 32'(w[8:0]), 32'd0);
        chk("t1_tot", 32'(6'(g2b(w[20:15]) - g2b(w[14:9]))), 32'd8);
        chk("t1_token_drop", 32'(ro.token), 32'd0);

        // 2: two overlapping hits, column priority
        ana_hit[0] = 1'b1;
        cyc();
        ana_hit[11] = 1'b1;
        repeat (7) cyc();
        ana_hit[0] = 1'b0;
        cyc();
        ana_hit[11] = 1'b0;
        repeat (2) cyc();
        read_word(w);
        chk("t2_w1_col", 32'(w[26:21]), 32'd0);
        chk("t2_w1_row", 32'(w[8:0]), 32'd0);
        chk("t2_token_mid", 32'(ro.token), 32'd1);
        read_word(w);
        chk("t2_w2_col", 32'(w[26:21]), 32'd3);
        chk("t2_w2_row", 32'(w[8:0]), 32'd2);
        chk("t2_token_end", 32'(ro.token), 32'd0);

        // 3: injection into (r5,c2) with and without monitor selection
        inj_col = 4'b0100; inj_row = 8'b0010_0000; dig_mon_sel = 4'b0100;
        cnt = 0;
        inj_pulse = 1'b1;
        repeat (4) begin cyc(); cnt += int'(ro.hit_or); end
        inj_pulse = 1'b0;
        repeat (2) begin cyc(); cnt += int'(ro.hit_or); end
        chk("t3_hit_or_cycles", 32'(cnt), 32'd4);
        read_word(w);
        chk("t3_col", 32'(w[26:21]), 32'd2);
        chk("t3_row", 32'(w[8:0]), 32'd5);
        chk("t3_tot", 32'(6'(g2b(w[20:15]) - g2b(w[14:9]))), 32'd4);
        dig_mon_sel = '0;
        cnt = 0;
        inj_pulse = 1'b1;
        repeat (4) begin cyc(); cnt += int'(ro.hit_or); end
        inj_pulse = 1'b0;
        repeat (2) begin cyc(); cnt += int'(ro.hit_or); end
        chk("t3_hit_or_unsel", 32'(cnt), 32'd0);
        read_word(w);
        inj_col = '0; inj_row = '0;

        // 4: freeze holds back a hit; disabled column ignores it
        ro.freeze = 1'b1;
        ana_hit[5] = 1'b1;
        repeat (3) cyc();
        ana_hit[5] = 1'b0;
        repeat (4) cyc();
        chk("t4_token_frozen", 32'(ro.token), 32'd0);
        ro.freeze = 1'b0;
        cyc();
        chk("t4_token_unfrozen", 32'(ro.token), 32'd1);
        read_word(w);
        chk("t4_col", 32'(w[26:21]), 32'd1);
        chk("t4_row", 32'(w[8:0]), 32'd1);
        en_col[1] = 1'b0;
        ana_hit[5] = 1'b1;
        repeat (3) cyc();
        ana_hit[5] = 1'b0;
        repeat (4) cyc();
        chk("t4_token_disabled", 32'(ro.token), 32'd0);
        en_col[1] = 1'b1;

        // 5: empty read, then BCID clear followed by a 1-cycle hit
        read_word(w);
        chk("t5_empty_word", 32'(w), 32'd0);
        reset_bcid = 1'b1;
        cyc();
        reset_bcid = 1'b0;
        repeat (3) cyc();
        ana_hit[0] = 1'b1;
        cyc();
        ana_hit[0] = 1'b0;
        repeat (2) cyc();
        read_word(w);
        chk("t5_le", 32'(w[14:9]), 32'b000010);
        chk("t5_te", 32'(w[20:15]), 32'b000110);

        // 6: reset during shift-out
        ana_hit[0] = 1'b1; ana_hit[1] = 1'b1;
        repeat (2) cyc();
        ana_hit[0] = 1'b0; ana_hit[1] = 1'b0;
        repeat (2) cyc();
        ro.read = 1'b1;
        cyc();
        ro.read = 1'b0;
        repeat (3) cyc();
        chk("t6_token_pending", 32'(ro.token), 32'd1);
        do_reset();
        repeat (2) cyc();
        chk("t6_token_after", 32'(ro.token), 32'd0);
        read_word(w);
        chk("t6_idle_word", 32'(w), 32'd0);

        // randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            for (int p = 0; p < NPIX; p++)
                if ($urandom_range(0, 39) == 0) ana_hit[p] = ~ana_hit[p];
            en_col = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
            inj_pulse = ($urandom_range(0, 29) == 0);
            inj_col = 4'($urandom);
            inj_row = 8'($urandom);
            dig_mon_sel = 4'($urandom);
            reset_bcid = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 19) == 0) ro.freeze = ~ro.freeze;
            ro.read = ($urandom_range(0, 11) == 0);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
